cnn_window_streamer: RTL
========================

// Module: cnn_window_streamer
// PURPOSE
//  Feeds the ternary-comparator convolution engine. Accepts an activation image as a raster pixel stream
//  (valid/ready) and emits every 3x3 "valid" convolution window as a parallel 9-pixel bundle (valid/ready).
//  Two line buffers plus a 3x3 shift array produce the window; the engine consumes one window per transfer.
//  The window index order matches the engine's Act[0..8] (row-major, top row first).
// PARAMETERS
//  DW     9  signed pixel width
//  IMG_W  5  image width in pixels (>=3)
//  IMG_H  5  image height in pixels (>=3)
//  CW     4  coordinate width; must satisfy 2**CW >= max(IMG_W,IMG_H)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_data    in   DW     signed pixel, raster order (row 0 col 0 first)
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      streamer can accept in_data this cycle
//  win_data   out  9*DW   window; element k = win_data[k*DW +: DW], k = 3*r + c (r,c = 0..2, r=0 top)
//  win_valid  out  1      win_data/win_row/win_col hold a window
//  win_ready  in   1      consumer accepts the window this cycle
//  win_row    out  CW     output row index of window (0..IMG_H-3)
//  win_col    out  CW     output col index of window (0..IMG_W-3)
//  win_last   out  1      only with CNN_WIN_LAST_EN (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high. Reset values: win_valid=0, win_data=0, win_row=0,
//    win_col=0, win_last=0, pixel col/row counters=0. in_ready=1 in the cycle after reset.
//    Line-buffer/shift-array contents are not reset (never exposed before being overwritten).
//  - Pixel accepted when in_valid && in_ready. in_ready = !win_valid || win_ready (1-entry output register).
//  - On accept at (row,col): shift array column shift; new right column = {lb1[col], lb0[col], in_data}
//    (top..bottom); then lb1[col] <= lb0[col], lb0[col] <= in_data. col increments; at IMG_W-1 wraps to 0
//    and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame starts immediately, no gap).
//  - Window emitted iff accepted pixel has row>=2 and col>=2: next cycle win_valid=1, win_row=row-2,
//    win_col=col-2, win_data = 3x3 neighbourhood ending at that pixel. Latency: 1 cycle after the accept
//    of the bottom-right pixel. Windows per frame = (IMG_W-2)*(IMG_H-2).
//  - Output stable while win_valid && !win_ready. win_valid clears on win_ready unless a same-cycle accept
//    creates a new window (simultaneous drain+fill: new window loaded, win_valid stays 1, no bubble).
//  - Pixels with col<2 or row<2 update buffers only; no window.
//  - Pixels are stored verbatim (sign preserved, no arithmetic); win_data is concatenation only.
//  - Reset mid-frame: partial frame discarded, any pending window dropped; next pixel is row 0 col 0.
//  - in_data ignored when !in_valid; no pixel lost or duplicated under any valid/ready pattern.
// CONFIGURATION
//  CNN_WIN_LAST_EN defined: win_last port exists; win_last=1 with the window where
//    win_row=IMG_H-3 && win_col=IMG_W-3 (final window of frame), else 0; held with win_data while stalled.
//  Not defined: win_last port absent; no other behaviour changes.
// TESTING
//  T1 5x5 frame, pixel=5r+c, win_ready=1 -> 9 windows; first {0,1,2,5,6,7,10,11,12} (0,0); last
//     {12,13,14,17,18,19,22,23,24} (2,2); each 1 cycle after its bottom-right pixel.
//  T2 T1 with win_ready low 4 cycles at first window -> win_data held, in_ready=0, no pixel lost.
//  T3 all pixels -256, then +255 -> every element reads -256 / +255 exactly (sign preserved).
//  T4 two frames back-to-back, continuous in_valid -> 18 windows; frame 2 window (0,0) uses only frame 2.
//  T5 reset after 13 pixels, then fresh frame -> no window from pre-reset data; T1 sequence reproduced.
//  T6 CNN_WIN_LAST_EN: win_last=1 only on window (2,2) of each frame; random in_valid/win_ready gaps.

Source files
------------

// File: rtl/cnn_window_streamer.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_streamer
// Description : Raster pixel stream in, every 3x3 valid convolution window out
//               (row-major bundle, top row first). Optional win_last port is
//               enabled by defining CNN_WIN_LAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_window_streamer #(
    parameter int DW    = 9,
    parameter int IMG_W = 5,
    parameter int IMG_H = 5,
    parameter int CW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [9*DW-1:0]   win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [CW-1:0]     win_row,
`ifdef CNN_WIN_LAST_EN
    output logic              win_last,
`endif
    output logic [CW-1:0]     win_col
);

    localparam int            AW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] c_col_max = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_row_max = CW'(IMG_H - 1);
    localparam logic [CW-1:0] c_two     = CW'(2);

    logic [CW-1:0]   col_q, row_q;
    logic [DW-1:0]   lb0_q [IMG_W];
    logic [DW-1:0]   lb1_q [IMG_W];
    logic [DW-1:0]   sa_q  [3][2];
    logic [9*DW-1:0] win_data_q, win_data_d;
    logic            win_valid_q;
    logic            win_last_q;
    logic [CW-1:0]   win_row_q, win_col_q;

    logic [AW-1:0]   w_idx;
    logic [DW-1:0]   w_newcol [3];
    logic            w_accept;
    logic            w_emit;

    assign w_idx    = col_q[AW-1:0];
    assign in_ready = !win_valid_q || win_ready;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = w_accept && (row_q >= c_two) && (col_q >= c_two);

    // Window = two stored columns plus the incoming column, assembled row by row.
    always_comb begin
        w_newcol[0] = lb1_q[w_idx];
        w_newcol[1] = lb0_q[w_idx];
        w_newcol[2] = in_data;
        win_data_d  = '0;
        for (int r = 0; r < 3; r++) begin
            win_data_d[(3*r+0)*DW +: DW] = sa_q[r][0];
            win_data_d[(3*r+1)*DW +: DW] = sa_q[r][1];
            win_data_d[(3*r+2)*DW +: DW] = w_newcol[r];
        end
    end

    // Storage is never visible before being overwritten, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb1_q[w_idx] <= lb0_q[w_idx];
            lb0_q[w_idx] <= in_data;
            for (int r = 0; r < 3; r++) begin
                sa_q[r][0] <= sa_q[r][1];
                sa_q[r][1] <= w_newcol[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (col_q == c_col_max) begin
                    col_q <= '0;
                    row_q <= (row_q == c_row_max) ? '0 : row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (w_emit) begin
                win_valid_q <= 1'b1;
                win_data_q  <= win_data_d;
                win_row_q   <= row_q - c_two;
                win_col_q   <= col_q - c_two;
                win_last_q  <= (row_q == c_row_max) && (col_q == c_col_max);
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
`ifdef CNN_WIN_LAST_EN
    assign win_last  = win_last_q;
`else
    logic w_unused_last;
    assign w_unused_last = win_last_q;
`endif

endmodule
`default_nettype wire
